// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and default widths for the CNN address sequencers
package cnn_pkg;

  localparam int DIM_W_DEF  = 5;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - mod-(limit+1) up-counter with terminal-count flag
module wrap_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         tc
);

  // limit is the last value visited, so a limit of 0 keeps tc permanently high
  assign tc = (count == limit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/conv_window_seq.sv
// rtl/conv_window_seq.sv - convolution window read-address sequencer
module conv_window_seq
  import cnn_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM_W  = DIM_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [2:0]        kern_w,
  input  logic [1:0]        stride,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              win_first,
  output logic              win_last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  seq_state_e state, state_nxt;

  logic [DIM_W-1:0]  kern_ext, span, pos_lim_nxt;
  logic [ADDR_W-1:0] img_ext, row_step_nxt;
  logic              legal, accept, hs;
  logic              ky_en, ox_en, oy_en, last_tap;

  logic [2:0]        kern_lim;
  logic [DIM_W-1:0]  pos_lim;
  logic [ADDR_W-1:0] img_r, stride_r, row_step;
  logic [ADDR_W-1:0] row_base, win_base, tap_row, addr_r;
  logic [ADDR_W-1:0] tap_row_nxt, win_base_nxt, row_base_nxt;

  logic [2:0]        kx_cnt, ky_cnt;
  logic [DIM_W-1:0]  ox_cnt, oy_cnt;
  logic              kx_tc, ky_tc, ox_tc, oy_tc;
  logic              unused_pos;

  assign kern_ext = DIM_W'(kern_w);
  assign img_ext  = ADDR_W'(img_w);
  assign legal    = (kern_w != 3'd0) && (stride != 2'd0) && (kern_ext <= img_w);
  assign accept   = start && (state == ST_IDLE) && legal;
  assign span     = img_w - kern_ext;

  // Last output index and the address step between output rows, stride 1..3 only
  always_comb begin
    pos_lim_nxt  = span;
    row_step_nxt = img_ext;
    case (stride)
      2'd2: begin
        pos_lim_nxt  = span >> 1;
        row_step_nxt = img_ext << 1;
      end
      2'd3: begin
        pos_lim_nxt  = span / DIM_W'(3);
        row_step_nxt = img_ext + (img_ext << 1);
      end
      default: ;
    endcase
  end

  assign hs       = addr_valid && addr_ready;
  assign ky_en    = hs && kx_tc;
  assign ox_en    = ky_en && ky_tc;
  assign oy_en    = ox_en && ox_tc;
  assign last_tap = oy_en && oy_tc;

  wrap_counter #(.W(3)) u_kx (
    .clk(clk), .rst_n(rst_n), .clr(accept), .en(hs),
    .limit(kern_lim), .count(kx_cnt), .tc(kx_tc)
  );
  wrap_counter #(.W(3)) u_ky (
    .clk(clk), .rst_n(rst_n), .clr(accept), .en(ky_en),
    .limit(kern_lim), .count(ky_cnt), .tc(ky_tc)
  );
  wrap_counter #(.W(DIM_W)) u_ox (
    .clk(clk), .rst_n(rst_n), .clr(accept), .en(ox_en),
    .limit(pos_lim), .count(ox_cnt), .tc(ox_tc)
  );
  wrap_counter #(.W(DIM_W)) u_oy (
    .clk(clk), .rst_n(rst_n), .clr(accept), .en(oy_en),
    .limit(pos_lim), .count(oy_cnt), .tc(oy_tc)
  );

  assign unused_pos = ^{ox_cnt, oy_cnt};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    addr_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_RUN;
      ST_RUN: begin
        addr_valid = 1'b1;
        busy       = 1'b1;
        if (last_tap) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign addr      = addr_r;
  assign win_first = addr_valid && (kx_cnt == 3'd0) && (ky_cnt == 3'd0);
  assign win_last  = addr_valid && kx_tc && ky_tc;

  // Nested running bases: output row -> window origin -> tap row -> tap
  assign tap_row_nxt  = tap_row + img_r;
  assign win_base_nxt = win_base + stride_r;
  assign row_base_nxt = row_base + row_step;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kern_lim <= '0;
      pos_lim  <= '0;
      img_r    <= '0;
      stride_r <= '0;
      row_step <= '0;
      row_base <= '0;
      win_base <= '0;
      tap_row  <= '0;
      addr_r   <= '0;
    end else if (accept) begin
      kern_lim <= kern_w - 3'd1;
      pos_lim  <= pos_lim_nxt;
      img_r    <= img_ext;
      stride_r <= ADDR_W'(stride);
      row_step <= row_step_nxt;
      row_base <= base_addr;
      win_base <= base_addr;
      tap_row  <= base_addr;
      addr_r   <= base_addr;
    end else if (hs) begin
      if (!kx_tc) begin
        addr_r <= addr_r + 1'b1;
      end else if (!ky_tc) begin
        tap_row <= tap_row_nxt;
        addr_r  <= tap_row_nxt;
      end else if (!ox_tc) begin
        win_base <= win_base_nxt;
        tap_row  <= win_base_nxt;
        addr_r   <= win_base_nxt;
      end else if (!oy_tc) begin
        row_base <= row_base_nxt;
        win_base <= row_base_nxt;
        tap_row  <= row_base_nxt;
        addr_r   <= row_base_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                           cfg_err <= 1'b0;
    else if (start && (state == ST_IDLE)) cfg_err <= !legal;
  end

endmodule

// File: tb/tb_conv_window_seq.sv
// tb/tb_conv_window_seq.sv - randomized self-checking bench for conv_window_seq
module tb_conv_window_seq;

  localparam int ADDR_W = 10;
  localparam int DIM_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  img_w = '0;
  logic [2:0]        kern_w = '0;
  logic [1:0]        stride = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              addr_ready = 1'b0;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid, win_first, win_last, busy, done, cfg_err;

  int n_pass  = 0;
  int n_total = 0;

  logic [ADDR_W-1:0] exp_a[$];
  bit                exp_f[$];
  bit                exp_l[$];

  conv_window_seq #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .img_w(img_w), .kern_w(kern_w),
    .stride(stride), .base_addr(base_addr), .addr(addr), .addr_valid(addr_valid),
    .addr_ready(addr_ready), .win_first(win_first), .win_last(win_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: direct formula over the four nested loops
  task automatic build_model(input int img, input int k, input int s, input int base);
    int ow, a;
    exp_a.delete(); exp_f.delete(); exp_l.delete();
    ow = (img - k) / s + 1;
    for (int oy = 0; oy < ow; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            a = (base + (oy * s + ky) * img + ox * s + kx) % (1 << ADDR_W);
            exp_a.push_back(ADDR_W'(a));
            exp_f.push_back(ky == 0 && kx == 0);
            exp_l.push_back(ky == k - 1 && kx == k - 1);
          end
  endtask

  task automatic run_pass(input int img, input int k, input int s, input int base,
                          input bit bp, input bit poke, input string tag,
                          output int done_cyc);
    int idx, cyc, n;
    logic [ADDR_W-1:0] held_a;
    logic held_f, held_l;
    bit stalled;
    build_model(img, k, s, base);
    n = exp_a.size();
    img_w = DIM_W'(img); kern_w = 3'(k); stride = 2'(s); base_addr = ADDR_W'(base);
    addr_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    img_w = DIM_W'($urandom); kern_w = 3'($urandom); stride = 2'($urandom);
    base_addr = ADDR_W'($urandom);
    n_total++;
    if (busy !== 1'b1 || addr_valid !== 1'b1 || cfg_err !== 1'b0)
      $display("FAIL %s start_accept: busy=%b valid=%b cfg_err=%b, want 1 1 0",
               tag, busy, addr_valid, cfg_err);
    else n_pass++;
    cyc = 2; idx = 0; stalled = 0; done_cyc = -1;
    held_a = '0; held_f = 1'b0; held_l = 1'b0;
    while (idx < n && cyc < 5000) begin
      addr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      start = poke && (cyc == 4);
      n_total++;
      if (addr_valid !== 1'b1)
        $display("FAIL %s valid idx=%0d: got %b want 1", tag, idx, addr_valid);
      else n_pass++;
      if (stalled) begin
        n_total++;
        if (addr !== held_a || win_first !== held_f || win_last !== held_l)
          $display("FAIL %s stall_hold idx=%0d: got %0d/%b/%b want %0d/%b/%b",
                   tag, idx, addr, win_first, win_last, held_a, held_f, held_l);
        else n_pass++;
      end
      n_total++;
      if (addr !== exp_a[idx] || win_first !== exp_f[idx] || win_last !== exp_l[idx])
        $display("FAIL %s tap idx=%0d: got addr=%0d first=%b last=%b want %0d %b %b",
                 tag, idx, addr, win_first, win_last, exp_a[idx], exp_f[idx], exp_l[idx]);
      else n_pass++;
      held_a = addr; held_f = win_first; held_l = win_last;
      stalled = !addr_ready;
      if (addr_ready) idx++;
      tick();
      cyc++;
    end
    start = 1'b0;
    addr_ready = 1'b0;
    n_total++;
    if (idx < n) begin
      $display("FAIL %s timeout: got %0d handshakes want %0d", tag, idx, n);
    end else if (done !== 1'b1 || addr_valid !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL %s done_cycle: done=%b valid=%b busy=%b want 1 0 1",
               tag, done, addr_valid, busy);
    end else begin
      n_pass++;
      done_cyc = cyc;
    end
    tick();
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0 || addr_valid !== 1'b0 || cfg_err !== 1'b0)
      $display("FAIL %s after_done: done=%b busy=%b valid=%b cfg_err=%b want 0 0 0 0",
               tag, done, busy, addr_valid, cfg_err);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1; img_w = 5'd4; kern_w = 3'd3; stride = 2'd1;
    repeat (3) tick();
    n_total++;
    if ({addr, addr_valid, win_first, win_last, busy, done, cfg_err} !== '0)
      $display("FAIL reset_outputs: addr=%0d valid=%b first=%b last=%b busy=%b done=%b err=%b want all 0",
               addr, addr_valid, win_first, win_last, busy, done, cfg_err);
    else n_pass++;
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    n_total++;
    if (busy !== 1'b0 || addr_valid !== 1'b0)
      $display("FAIL reset_release: busy=%b valid=%b want 0 0", busy, addr_valid);
    else n_pass++;
  endtask

  task automatic test_basic();
    int dc;
    run_pass(4, 3, 1, 0, 1'b0, 1'b0, "basic", dc);
    n_total++;
    if (dc !== 38) $display("FAIL basic_done_cycle: got %0d want 38", dc);
    else n_pass++;
  endtask

  task automatic test_stride_base();
    int dc;
    run_pass(5, 3, 2, 100, 1'b0, 1'b0, "stride2", dc);
    run_pass(6, 2, 1, 1020, 1'b0, 1'b0, "wrap", dc);
  endtask

  task automatic test_backpressure();
    int dc;
    run_pass(4, 3, 1, 0, 1'b1, 1'b0, "backpressure", dc);
  endtask

  task automatic test_bad_cfg();
    int dc;
    int bad_k[3] = '{5, 0, 3};
    int bad_s[3] = '{1, 1, 0};
    for (int i = 0; i < 3; i++) begin
      img_w = 5'd4; kern_w = 3'(bad_k[i]); stride = 2'(bad_s[i]); base_addr = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_total++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || addr_valid !== 1'b0)
        $display("FAIL bad_cfg%0d: err=%b busy=%b valid=%b want 1 0 0",
                 i, cfg_err, busy, addr_valid);
      else n_pass++;
      repeat (3) tick();
      n_total++;
      if (addr_valid !== 1'b0 || cfg_err !== 1'b1)
        $display("FAIL bad_cfg%0d_hold: valid=%b err=%b want 0 1", i, addr_valid, cfg_err);
      else n_pass++;
    end
    run_pass(4, 2, 1, 3, 1'b0, 1'b0, "cfg_clear", dc);
  endtask

  task automatic test_reset_mid();
    int dc, idx, cyc;
    bit saw_done;
    img_w = 5'd4; kern_w = 3'd3; stride = 2'd1; base_addr = 10'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    addr_ready = 1'b1;
    idx = 0; cyc = 0;
    while (idx < 9 && cyc < 100) begin
      if (addr_valid) idx++;
      tick();
      cyc++;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_total++;
    if ({addr, addr_valid, win_first, win_last, busy, done, cfg_err} !== '0)
      $display("FAIL reset_mid_outputs: addr=%0d valid=%b busy=%b done=%b want all 0",
               addr, addr_valid, busy, done);
    else n_pass++;
    saw_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (done !== 1'b0 || addr_valid !== 1'b0) saw_done = 1;
      tick();
    end
    n_total++;
    if (saw_done) $display("FAIL reset_mid_quiet: got activity after abort want none");
    else n_pass++;
    addr_ready = 1'b0;
    run_pass(4, 3, 1, 7, 1'b0, 1'b0, "restart", dc);
  endtask

  task automatic test_1x1();
    int dc;
    run_pass(3, 1, 1, 0, 1'b0, 1'b0, "k1", dc);
  endtask

  task automatic test_back_to_back();
    int dc, img, k, s, base;
    for (int i = 0; i < 8; i++) begin
      img  = $urandom_range(1, 12);
      k    = $urandom_range(1, (img < 7) ? img : 7);
      s    = $urandom_range(1, 3);
      base = $urandom_range(0, (1 << ADDR_W) - 1);
      run_pass(img, k, s, base, 1'($urandom_range(0, 1)), 1'b1, "random", dc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stride_base();
    test_backpressure();
    test_bad_cfg();
    test_reset_mid();
    test_1x1();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/conv_window_seq.md
CONV_WINDOW_SEQ -- requirements
Module: conv_window_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, giving the feature-buffer address width (28x28 = 784 fits).
REQ-002 SHALL have parameter DIM_W, default 5, giving the width of the image-dimension fields.
REQ-003 SHALL have one clock and a synchronous, active-low reset.
REQ-004 SHALL have port: clk  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port: start  input  1  one-cycle request to begin a layer pass.
REQ-007 SHALL have port: img_w  input  DIM_W  square input image side, in pixels.
REQ-008 SHALL have port: kern_w  input  3  square kernel side, legal range 1..7.
REQ-009 SHALL have port: stride  input  2  window step, legal range 1..3.
REQ-010 SHALL have port: base_addr  input  ADDR_W  address of pixel (0,0).
REQ-011 SHALL have port: addr  output  ADDR_W  feature-buffer read address.
REQ-012 SHALL have port: addr_valid  output  1  addr is meaningful.
REQ-013 SHALL have port: addr_ready  input  1  consumer accepts addr this cycle.
REQ-014 SHALL have port: win_first  output  1  addr is tap (0,0) of a window.
REQ-015 SHALL have port: win_last  output  1  addr is the last tap of a window.
REQ-016 SHALL have port: busy  output  1  a pass is in progress.
REQ-017 SHALL have port: done  output  1  one-cycle pulse when a pass completes.
REQ-018 SHALL have port: cfg_err  output  1  sticky flag: illegal configuration was rejected.

Function
REQ-019 SHALL implement states IDLE, RUN and DONE.
- IDLE->RUN: on start when the configuration is legal.
- RUN->DONE: on the handshake of the final address.
- DONE->IDLE: unconditionally, next cycle.
REQ-020 SHALL latch img_w, kern_w, stride and base_addr on the start cycle; later changes to these inputs have no effect on the pass in progress.
REQ-021 SHALL treat the configuration as illegal when kern_w==0, stride==0 or kern_w>img_w. On start with an illegal configuration it stays in IDLE and sets cfg_err.
REQ-022 SHALL clear cfg_err on a start with a legal configuration.
REQ-023 SHALL compute out_w = (img_w - kern_w)/stride + 1 using floor division.
REQ-024 SHALL visit every output position (oy,ox), each 0..out_w-1, in row-major order.
REQ-025 SHALL, within each window, emit taps (ky,kx) in row-major order, each 0..kern_w-1.
REQ-026 SHALL emit addr = base_addr + (oy*stride+ky)*img_w + ox*stride + kx, modulo 2^ADDR_W.
- Generated with incremental adders and counters only; no multipliers.
REQ-027 SHALL assert addr_valid in the cycle after start is accepted, and hold it high through RUN.
REQ-028 SHALL advance to the next tap only on a cycle where addr_valid and addr_ready are both high.
REQ-029 SHALL hold addr, win_first and win_last stable while addr_valid is high and addr_ready is low.
REQ-030 SHALL sustain one address per cycle when addr_ready is held high.
REQ-031 SHALL assert busy in RUN and DONE.
REQ-032 SHALL pulse done for exactly the one cycle spent in DONE; addr_valid is low in that cycle.
REQ-033 SHALL ignore start while busy.
REQ-034 SHALL produce kern_w^2 * out_w^2 handshakes per pass, exactly.
REQ-035 SHALL, when kern_w==1, assert win_first and win_last on every tap.

Reset
REQ-036 SHALL, on rst_n low at a clock edge, enter IDLE and zero all counters.
REQ-037 SHALL set addr, addr_valid, win_first, win_last, busy, done and cfg_err to 0 on reset.
REQ-038 SHALL treat reset during RUN as an abort: no done pulse, and no further addresses until the next start.

Structure
REQ-039 SHALL take its state enum, DIM_W and ADDR_W defaults from the shared package cnn_pkg.
REQ-040 SHALL build its tap and position counters from one sub-module, wrap_counter.
- wrap_counter is a mod-N up-counter with inputs en and limit, and a terminal-count output.
- Instantiated four times: kx, ky, ox, oy.

Verification
REQ-041 SHALL cover basic 3x3 traversal:
- Stimulus: img_w=4, kern_w=3, stride=1, base=0, ready always high.
- Response: 36 addresses; first window 0,1,2,4,5,6,8,9,10; next windows start at 1, 4 and 5.
- done is high exactly on cycle 38 after start.
REQ-042 SHALL cover stride 2 with a base offset:
- Stimulus: img_w=5, kern_w=3, stride=2, base=100.
- Response: windows start at 100, 102, 110 and 112; 36 handshakes.
REQ-043 SHALL cover backpressure:
- Stimulus: the 4x4/3/1 case with ready toggled pseudo-randomly.
- Response: the same 36-address sequence; addr held stable whenever ready is low.
REQ-044 SHALL cover rejected configuration:
- Stimulus: img_w=4, kern_w=5, then start.
- Response: cfg_err=1, busy stays 0, no addr_valid.
- A following legal start clears cfg_err.
REQ-045 SHALL cover reset mid-pass:
- Stimulus: rst_n low at the 10th handshake.
- Response: all outputs 0 on the next cycle, no done pulse; a restart begins again at base_addr.
REQ-046 SHALL cover the 1x1 kernel:
- Stimulus: img_w=3, kern_w=1, stride=1.
- Response: addresses 0..8, win_first and win_last high on every tap.
